// File: rtl/add_accum_if.sv
// Request/result handshake bundle for add_accum: one request channel, one result channel.
interface add_accum_if #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2
);
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH*CHANNELS-1:0] y;
  logic [WIDTH*CHANNELS-1:0] z;
  logic                      mode;
  logic                      clear;
  logic                      out_valid;
  logic                      out_ready;
  logic [WIDTH*CHANNELS-1:0] sum;
  logic [CHANNELS-1:0]       ovf;

  modport master (
    output in_valid, y, z, mode, clear, out_ready,
    input  in_ready, out_valid, sum, ovf
  );

  modport slave (
    input  in_valid, y, z, mode, clear, out_ready,
    output in_ready, out_valid, sum, ovf
  );
endinterface

// File: rtl/add_accum.sv
// Multi-lane adder/accumulator with a one-deep registered result stage.
// Each lane adds y+z (mode 0) or acc+y+z (mode 1), with optional saturation.
module add_accum #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 2,
  parameter int SATURATE = 0
) (
  input logic       clk,
  input logic       rst_n,
  add_accum_if.slave bus
);
  localparam int FW = WIDTH + 2;

  logic                accept;
  logic                out_valid_reg;
  logic [CHANNELS-1:0] ovf_reg;
  logic [CHANNELS-1:0] lane_ovf;
  logic [WIDTH-1:0]    sum_reg  [CHANNELS];
  logic [WIDTH-1:0]    acc_reg  [CHANNELS];
  logic [WIDTH-1:0]    acc_next [CHANNELS];
  logic [WIDTH-1:0]    lane_res [CHANNELS];

  // The result stage can take a new request whenever it is empty or being drained.
  assign bus.in_ready  = !out_valid_reg || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.ovf       = ovf_reg;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      logic [WIDTH-1:0] y_l;
      logic [WIDTH-1:0] z_l;
      logic [WIDTH-1:0] acc_op;
      logic [FW-1:0]    full;

      assign y_l    = bus.y[gi*WIDTH +: WIDTH];
      assign z_l    = bus.z[gi*WIDTH +: WIDTH];
      assign acc_op = bus.clear ? '0 : acc_reg[gi];
      assign full   = {2'b00, y_l} + {2'b00, z_l} + (bus.mode ? {2'b00, acc_op} : '0);

      assign lane_ovf[gi] = |full[FW-1:WIDTH];
      assign lane_res[gi] = ((SATURATE != 0) && lane_ovf[gi]) ? '1 : full[WIDTH-1:0];

      // Accumulate mode tracks the (possibly clamped) lane result; plain add only honours clear.
      assign acc_next[gi] = bus.mode ? lane_res[gi] : (bus.clear ? '0 : acc_reg[gi]);

      assign bus.sum[gi*WIDTH +: WIDTH] = sum_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      ovf_reg       <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        sum_reg[i] <= '0;
        acc_reg[i] <= '0;
      end
    end else begin
      if (accept) begin
        out_valid_reg <= 1'b1;
        ovf_reg       <= lane_ovf;
        for (int i = 0; i < CHANNELS; i++) begin
          sum_reg[i] <= lane_res[i];
          acc_reg[i] <= acc_next[i];
        end
      end else if (bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_add_accum.sv
// Directed + random bench for add_accum: wrap and saturating instances share stimulus,
// expected results come from a lane model through a FIFO scoreboard.
module tb_add_accum;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  typedef struct packed {
    logic [15:0] s0;
    logic [15:0] s1;
    logic [1:0]  o0;
    logic [1:0]  o1;
  } exp_t;

  exp_t q[$];
  int   macc0[2];
  int   macc1[2];

  add_accum_if #(.WIDTH(8), .CHANNELS(2)) bus0 ();
  add_accum_if #(.WIDTH(8), .CHANNELS(2)) bus1 ();

  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.y         = bus0.y;
  assign bus1.z         = bus0.z;
  assign bus1.mode      = bus0.mode;
  assign bus1.clear     = bus0.clear;
  assign bus1.out_ready = bus0.out_ready;

  add_accum #(.WIDTH(8), .CHANNELS(2), .SATURATE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  add_accum #(.WIDTH(8), .CHANNELS(2), .SATURATE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void lane_model(input bit sat, input int yv, input int zv, input int acc,
                                     input bit md, input bit clr,
                                     output int res, output bit ov, output int acc_new);
    int a;
    int full;
    a       = clr ? 0 : acc;
    full    = md ? (a + yv + zv) : (yv + zv);
    ov      = (full > 255);
    res     = (ov && sat) ? 255 : (full % 256);
    acc_new = md ? res : (clr ? 0 : acc);
  endfunction

  task automatic push_req(input logic [15:0] yv, input logic [15:0] zv, input bit md, input bit clr);
    exp_t e;
    int   r;
    bit   o;
    int   an;
    e = '0;
    for (int l = 0; l < 2; l++) begin
      lane_model(1'b0, int'(yv[l*8 +: 8]), int'(zv[l*8 +: 8]), macc0[l], md, clr, r, o, an);
      e.s0[l*8 +: 8] = 8'(r);
      e.o0[l]        = o;
      macc0[l]       = an;
      lane_model(1'b1, int'(yv[l*8 +: 8]), int'(zv[l*8 +: 8]), macc1[l], md, clr, r, o, an);
      e.s1[l*8 +: 8] = 8'(r);
      e.o1[l]        = o;
      macc1[l]       = an;
    end
    q.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic [15:0] yv, input logic [15:0] zv, input bit md, input bit clr);
    int n;
    n = 0;
    bus0.y = yv; bus0.z = zv; bus0.mode = md; bus0.clear = clr; bus0.in_valid = 1'b1;
    #1;
    while (!bus0.in_ready && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    chk("send_in_ready", 32'(bus0.in_ready), 32'd1);
    push_req(yv, zv, md, clr);
    @(negedge clk);
    bus0.in_valid = 1'b0;
  endtask

  // Scoreboard: every result is checked on the cycle it is consumed.
  always begin
    exp_t e;
    @(negedge clk); #2;
    if (rst_n && bus0.out_valid && bus0.out_ready) begin
      if (q.size() == 0) begin
        chk("pending_result", 32'(q.size()), 32'd1);
      end else begin
        e = q.pop_front();
        chk("sum_wrap", 32'(bus0.sum), 32'(e.s0));
        chk("ovf_wrap", 32'(bus0.ovf), 32'(e.o0));
        chk("sum_sat",  32'(bus1.sum), 32'(e.s1));
        chk("ovf_sat",  32'(bus1.ovf), 32'(e.o1));
        chk("out_valid_sat", 32'(bus1.out_valid), 32'd1);
      end
      $display("result sum=%h ovf=%b | sat sum=%h ovf=%b", bus0.sum, bus0.ovf, bus1.sum, bus1.ovf);
    end
  end

  initial begin
    total = 0; bad = 0;
    macc0 = '{0, 0}; macc1 = '{0, 0};
    rst_n = 1'b0;
    bus0.in_valid = 1'b0; bus0.y = '0; bus0.z = '0; bus0.mode = 1'b0; bus0.clear = 1'b0;
    bus0.out_ready = 1'b1;

    // Reset state
    #3;
    chk("rst_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("rst_sum",       32'(bus0.sum),       32'd0);
    chk("rst_ovf",       32'(bus0.ovf),       32'd0);
    chk("rst_in_ready",  32'(bus0.in_ready),  32'd1);
    chk("rst_sum_sat",   32'(bus1.sum),       32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_in_ready", 32'(bus0.in_ready), 32'd1);
    @(negedge clk);

    // Plain add with lane1 overflow
    send({8'd200, 8'd5}, {8'd100, 8'd2}, 1'b0, 1'b0);
    #1 chk("add_latency_valid", 32'(bus0.out_valid), 32'd1);
    @(negedge clk); @(negedge clk);

    // Back-to-back accumulate at full throughput
    send({8'd0, 8'd5}, {8'd0, 8'd2}, 1'b1, 1'b0);
    #1 chk("b2b_valid_1", 32'(bus0.out_valid), 32'd1);
    send({8'd0, 8'd0}, {8'd0, 8'd10}, 1'b1, 1'b0);
    #1 chk("b2b_valid_2", 32'(bus0.out_valid), 32'd1);
    @(negedge clk); @(negedge clk);

    // Backpressure: result held, next request blocked until out_ready returns
    bus0.out_ready = 1'b0;
    send({8'd1, 8'd3}, {8'd1, 8'd3}, 1'b0, 1'b0);
    bus0.y = {8'd9, 8'd9}; bus0.z = {8'd9, 8'd9}; bus0.mode = 1'b0; bus0.clear = 1'b0;
    bus0.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stall_in_ready", 32'(bus0.in_ready), 32'd0);
      chk("stall_sum",      32'(bus0.sum),      32'(q[0].s0));
      chk("stall_valid",    32'(bus0.out_valid), 32'd1);
      @(negedge clk);
    end
    bus0.out_ready = 1'b1;
    #1 chk("unstall_in_ready", 32'(bus0.in_ready), 32'd1);
    push_req({8'd9, 8'd9}, {8'd9, 8'd9}, 1'b0, 1'b0);
    @(negedge clk);
    bus0.in_valid = 1'b0;
    @(negedge clk); @(negedge clk);

    // Overflow: wrap vs clamp, in both modes
    send({8'd0, 8'd250}, {8'd0, 8'd10}, 1'b0, 1'b0);
    send({8'd255, 8'd250}, {8'd1, 8'd10}, 1'b1, 1'b0);

    // Clear with accumulate, then continue accumulating
    send({8'd0, 8'd7}, {8'd0, 8'd10}, 1'b1, 1'b1);
    send({8'd0, 8'd3}, {8'd0, 8'd4},  1'b1, 1'b1);
    send({8'd0, 8'd1}, {8'd0, 8'd0},  1'b1, 1'b0);
    // Clear in plain-add mode zeroes the accumulators
    send({8'd2, 8'd2}, {8'd2, 8'd2}, 1'b0, 1'b1);
    send({8'd1, 8'd1}, {8'd0, 8'd0}, 1'b1, 1'b0);
    @(negedge clk); @(negedge clk);

    // Random traffic with random backpressure
    for (int c = 0; c < 80; c++) begin
      bus0.out_ready = ($urandom_range(0, 3) != 0);
      bus0.in_valid  = ($urandom_range(0, 2) != 0);
      bus0.y         = 16'($urandom);
      bus0.z         = 16'($urandom);
      bus0.mode      = 1'($urandom);
      bus0.clear     = ($urandom_range(0, 7) == 0);
      #1;
      if (bus0.in_valid && bus0.in_ready)
        push_req(bus0.y, bus0.z, bus0.mode, bus0.clear);
      @(negedge clk);
    end
    bus0.in_valid = 1'b0; bus0.out_ready = 1'b1;
    @(negedge clk); @(negedge clk);

    // Mid-stream reset with a held result and acc=17
    send({8'd0, 8'd7}, {8'd0, 8'd10}, 1'b1, 1'b1);
    @(negedge clk); @(negedge clk);
    bus0.out_ready = 1'b0;
    send({8'd1, 8'd1}, {8'd1, 8'd1}, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus0.out_valid), 32'd0);
    chk("midrst_sum",       32'(bus0.sum),       32'd0);
    chk("midrst_ovf",       32'(bus0.ovf),       32'd0);
    chk("midrst_in_ready",  32'(bus0.in_ready),  32'd1);
    q.delete();
    macc0 = '{0, 0}; macc1 = '{0, 0};
    @(negedge clk);
    rst_n = 1'b1;
    bus0.out_ready = 1'b1;
    @(negedge clk);
    send({8'd0, 8'd1}, {8'd0, 8'd1}, 1'b1, 1'b0);
    @(negedge clk); @(negedge clk); @(negedge clk);

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/add_accum.md
ADD_ACCUM -- requirements
Module: add_accum

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the bit width of each channel operand and result.
REQ-002 Parameter CHANNELS, default 2, SHALL set the number of independent adder lanes.
REQ-003 Parameter SATURATE, default 0, SHALL select wrap (0) or clamp-to-all-ones (1) on overflow.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL indicate that y, z, mode and clear carry a valid request.
REQ-007 in_ready  output  1  SHALL indicate that the block accepts a request this cycle.
REQ-008 y  input  WIDTH*CHANNELS  SHALL carry operand A; lane i occupies bits [i*WIDTH +: WIDTH].
REQ-009 z  input  WIDTH*CHANNELS  SHALL carry operand B, packed like y.
REQ-010 mode  input  1  SHALL select plain add (0) or accumulate (1).
REQ-011 clear  input  1  SHALL request zeroing of all lane accumulators.
REQ-012 out_valid  output  1  SHALL indicate that sum and ovf hold a valid result.
REQ-013 out_ready  input  1  SHALL indicate that the consumer takes the result this cycle.
REQ-014 sum  output  WIDTH*CHANNELS  SHALL carry per-lane results, packed like y.
REQ-015 ovf  output  CHANNELS  SHALL carry per-lane overflow flags for the current result.

Function
REQ-016 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-017 A request SHALL be accepted on a rising edge where in_valid && in_ready; its result SHALL appear with out_valid=1 after exactly 1 cycle.
REQ-018 A result SHALL be consumed on a rising edge where out_valid && out_ready; with no accepted request that edge, out_valid SHALL fall to 0.
REQ-019 Simultaneous consume and accept SHALL load the new result with out_valid held at 1 (full throughput, 1 result per cycle).
REQ-020 While out_valid && !out_ready, sum and ovf SHALL hold stable and no request SHALL be accepted.
REQ-021 Mode 0: per lane, full = y_i + z_i, computed at WIDTH+1 bits; the accumulator SHALL NOT change.
REQ-022 Mode 1: per lane, full = acc_i + y_i + z_i, computed at WIDTH+2 bits; acc_i SHALL be loaded with the lane result.
REQ-023 ovf_i SHALL be 1 when full >= 2^WIDTH, else 0.
REQ-024 With SATURATE=0, lane result = full mod 2^WIDTH; with SATURATE=1, lane result = 2^WIDTH-1 when ovf_i=1, else full.
REQ-025 An accepted request with clear=1 SHALL use acc_i=0 as the operand (mode 1) and, in mode 0, SHALL zero all acc_i.
REQ-026 clear and mode SHALL be ignored when no request is accepted.
REQ-027 Lanes SHALL be fully independent; overflow in one lane SHALL NOT affect any other lane.

Reset
REQ-028 While rst_n=0, out_valid, sum, ovf and every acc_i SHALL be 0, taking effect asynchronously.
REQ-029 Consequently in_ready SHALL read 1 during and immediately after reset.
REQ-030 A request presented on the edge coinciding with rst_n deassertion SHALL NOT be accepted; acceptance begins on the first rising edge with rst_n=1.
REQ-031 Reset asserted mid-stream SHALL discard any held result and all accumulator state.

Verification
REQ-032 WIDTH=8, CHANNELS=2, SATURATE=0, mode 0: lane0 y=5,z=2; lane1 y=200,z=100 -> one cycle later sum lane0=7, lane1=44, ovf=2'b10.
REQ-033 Mode 1, out_ready=1, lane0 requests (y,z)=(5,2) then (0,10) back-to-back -> lane0 results 7 then 17, out_valid high on both cycles.
REQ-034 out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, sum frozen at first result; on out_ready=1 the next request is accepted that edge.
REQ-035 SATURATE=1, lane0 y=250,z=10 -> sum lane0=255, ovf[0]=1; SATURATE=0 same stimulus -> sum lane0=4, ovf[0]=1.
REQ-036 acc lane0=17, request mode 1, clear=1, y=3,z=4 -> sum lane0=7; subsequent mode 1 y=1,z=0 -> 8.
REQ-037 Assert rst_n=0 while out_valid=1 and acc=17 -> out_valid, sum, ovf drop to 0 immediately; next mode 1 y=1,z=1 -> sum=2.
